branch_resolve_unit: RTL and testbench

Parametrised branch execution stage for the execute cluster. It evaluates condition codes against flags, computes targets, and checks the result against the front-end prediction. It raises a single held redirect request (jump, SWI, interrupt return, IDTS) toward fetch with an acknowledge handshake, and broadcasts completion tags to a configurable number of schedulers. Saturating branch and mispredict counters are exported for the performance monitor.

---
 rtl/branch_resolve_unit_if.sv | 89 ++++++++
 rtl/branch_resolve_unit.sv | 209 ++++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_unit_if.sv
// Encodings shared by the branch resolve stage and its users, plus the bundled
// issue/redirect/completion port of the stage.
package branch_resolve_unit_pkg;
    localparam logic [4:0] EXE_BRANCH_BR   = 5'h00;
    localparam logic [4:0] EXE_BRANCH_BUR  = 5'h01;
    localparam logic [4:0] EXE_BRANCH_B    = 5'h02;
    localparam logic [4:0] EXE_BRANCH_BU   = 5'h03;
    localparam logic [4:0] EXE_BRANCH_SWI  = 5'h04;
    localparam logic [4:0] EXE_BRANCH_INTB = 5'h05;
    localparam logic [4:0] EXE_BRANCH_IDTS = 5'h06;

    localparam logic [3:0] CC_AL  = 4'h0;
    localparam logic [3:0] CC_EQ  = 4'h1;
    localparam logic [3:0] CC_NEQ = 4'h2;
    localparam logic [3:0] CC_MI  = 4'h3;
    localparam logic [3:0] CC_PL  = 4'h4;
    localparam logic [3:0] CC_EN  = 4'h5;
    localparam logic [3:0] CC_ON  = 4'h6;
    localparam logic [3:0] CC_OVF = 4'h7;
    localparam logic [3:0] CC_UEO = 4'h8;
    localparam logic [3:0] CC_UU  = 4'h9;
    localparam logic [3:0] CC_UO  = 4'hA;
    localparam logic [3:0] CC_UEU = 4'hB;
    localparam logic [3:0] CC_SEO = 4'hC;
    localparam logic [3:0] CC_SU  = 4'hD;
    localparam logic [3:0] CC_SO  = 4'hE;
    localparam logic [3:0] CC_SEU = 4'hF;

    localparam int unsigned FLAGS_CF = 0;
    localparam int unsigned FLAGS_OF = 1;
    localparam int unsigned FLAGS_SF = 2;
    localparam int unsigned FLAGS_PF = 3;
    localparam int unsigned FLAGS_ZF = 4;

    localparam logic [1:0] KIND_JUMP = 2'd0;
    localparam logic [1:0] KIND_SWI  = 2'd1;
    localparam logic [1:0] KIND_INTB = 2'd2;
    localparam logic [1:0] KIND_IDTS = 2'd3;
endpackage

interface branch_resolve_unit_if #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned TAG_W    = 6,
    parameter int unsigned NUM_SCHE = 2,
    parameter int unsigned CNT_W    = 16
);
    logic                iFREE_RESTART;
    logic                iPREVIOUS_EX_BRANCH_VALID;
    logic [TAG_W-1:0]    iPREVIOUS_EX_BRANCH_COMMIT_TAG;
    logic [4:0]          iPREVIOUS_EX_BRANCH_CMD;
    logic [3:0]          iPREVIOUS_EX_BRANCH_CC;
    logic [4:0]          iPREVIOUS_EX_BRANCH_FLAG;
    logic [ADDR_W-1:0]   iPREVIOUS_EX_BRANCH_SOURCE;
    logic [ADDR_W-1:0]   iPREVIOUS_EX_BRANCH_PC;
    logic                iPREVIOUS_EX_BRANCH_PRED_TAKEN;
    logic [ADDR_W-1:0]   iPREVIOUS_EX_BRANCH_PRED_ADDR;
    logic                oPREVIOUS_EX_BRANCH_LOCK;
    logic                oREDIRECT_VALID;
    logic                iREDIRECT_ACK;
    logic [1:0]          oREDIRECT_KIND;
    logic [ADDR_W-1:0]   oREDIRECT_ADDR;
    logic [TAG_W-1:0]    oREDIRECT_COMMIT_TAG;
    logic [10:0]         oSWI_NUMBER;
    logic [ADDR_W-1:0]   oIDTS_R_ADDR;
    logic [NUM_SCHE-1:0] oSCHE_EX_BRANCH_VALID;
    logic [TAG_W-1:0]    oSCHE_EX_BRANCH_COMMIT_TAG;
    logic [CNT_W-1:0]    oSTAT_BRANCH_CNT;
    logic [CNT_W-1:0]    oSTAT_MISPRED_CNT;

    modport slave (
        input  iFREE_RESTART, iPREVIOUS_EX_BRANCH_VALID, iPREVIOUS_EX_BRANCH_COMMIT_TAG,
               iPREVIOUS_EX_BRANCH_CMD, iPREVIOUS_EX_BRANCH_CC, iPREVIOUS_EX_BRANCH_FLAG,
               iPREVIOUS_EX_BRANCH_SOURCE, iPREVIOUS_EX_BRANCH_PC,
               iPREVIOUS_EX_BRANCH_PRED_TAKEN, iPREVIOUS_EX_BRANCH_PRED_ADDR, iREDIRECT_ACK,
        output oPREVIOUS_EX_BRANCH_LOCK, oREDIRECT_VALID, oREDIRECT_KIND, oREDIRECT_ADDR,
               oREDIRECT_COMMIT_TAG, oSWI_NUMBER, oIDTS_R_ADDR, oSCHE_EX_BRANCH_VALID,
               oSCHE_EX_BRANCH_COMMIT_TAG, oSTAT_BRANCH_CNT, oSTAT_MISPRED_CNT
    );

    modport master (
        output iFREE_RESTART, iPREVIOUS_EX_BRANCH_VALID, iPREVIOUS_EX_BRANCH_COMMIT_TAG,
               iPREVIOUS_EX_BRANCH_CMD, iPREVIOUS_EX_BRANCH_CC, iPREVIOUS_EX_BRANCH_FLAG,
               iPREVIOUS_EX_BRANCH_SOURCE, iPREVIOUS_EX_BRANCH_PC,
               iPREVIOUS_EX_BRANCH_PRED_TAKEN, iPREVIOUS_EX_BRANCH_PRED_ADDR, iREDIRECT_ACK,
        input  oPREVIOUS_EX_BRANCH_LOCK, oREDIRECT_VALID, oREDIRECT_KIND, oREDIRECT_ADDR,
               oREDIRECT_COMMIT_TAG, oSWI_NUMBER, oIDTS_R_ADDR, oSCHE_EX_BRANCH_VALID,
               oSCHE_EX_BRANCH_COMMIT_TAG, oSTAT_BRANCH_CNT, oSTAT_MISPRED_CNT
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch execute stage: resolves condition and target, checks the front-end
// prediction, raises one held redirect toward fetch and broadcasts completion.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned TAG_W    = 6,
    parameter int unsigned NUM_SCHE = 2,
    parameter int unsigned CNT_W    = 16
) (
    input logic iCLOCK,
    input logic inRESET,
    branch_resolve_unit_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic              w_lock;
    logic              w_redirect_valid;
    logic              w_restart;
    logic              w_accept;
    logic              w_taken;
    logic              w_redirect;
    logic [1:0]        w_kind;
    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W-1:0] w_target;
    logic [ADDR_W-1:0] w_pc4;
    logic              w_cf, w_of, w_sf, w_pf, w_zf;

    logic              r_sche_valid;
    logic [TAG_W-1:0]  r_sche_tag;
    logic [1:0]        r_kind;
    logic [ADDR_W-1:0] r_addr;
    logic [TAG_W-1:0]  r_rtag;
    logic [10:0]       r_swi;
    logic [ADDR_W-1:0] r_idts;
    logic [CNT_W-1:0]  r_bcnt;
    logic [CNT_W-1:0]  r_mcnt;

    assign w_restart = bus.iFREE_RESTART;
    assign w_accept  = bus.iPREVIOUS_EX_BRANCH_VALID && (r_state == ST_IDLE) && !w_restart;

    assign w_cf = bus.iPREVIOUS_EX_BRANCH_FLAG[FLAGS_CF];
    assign w_of = bus.iPREVIOUS_EX_BRANCH_FLAG[FLAGS_OF];
    assign w_sf = bus.iPREVIOUS_EX_BRANCH_FLAG[FLAGS_SF];
    assign w_pf = bus.iPREVIOUS_EX_BRANCH_FLAG[FLAGS_PF];
    assign w_zf = bus.iPREVIOUS_EX_BRANCH_FLAG[FLAGS_ZF];

    always_comb begin
        w_taken = 1'b1;
        case (bus.iPREVIOUS_EX_BRANCH_CC)
            CC_EQ:   w_taken = w_zf;
            CC_NEQ:  w_taken = !w_zf;
            CC_MI:   w_taken = w_sf;
            CC_PL:   w_taken = !w_sf;
            CC_EN:   w_taken = !w_pf;
            CC_ON:   w_taken = w_pf;
            CC_OVF:  w_taken = w_of;
            CC_UEO:  w_taken = w_cf;
            CC_UU:   w_taken = !w_cf;
            CC_UO:   w_taken = w_cf && !w_zf;
            CC_UEU:  w_taken = !w_cf || w_zf;
            CC_SEO:  w_taken = (w_sf == w_of);
            CC_SU:   w_taken = (w_sf != w_of);
            CC_SO:   w_taken = !((w_sf ^ w_of) || w_zf);
            CC_SEU:  w_taken = (w_sf ^ w_of) || w_zf;
            default: w_taken = 1'b1;
        endcase
    end

    assign w_target = ((bus.iPREVIOUS_EX_BRANCH_CMD == EXE_BRANCH_BR) ||
                       (bus.iPREVIOUS_EX_BRANCH_CMD == EXE_BRANCH_BUR))
                      ? bus.iPREVIOUS_EX_BRANCH_PC + bus.iPREVIOUS_EX_BRANCH_SOURCE
                      : bus.iPREVIOUS_EX_BRANCH_SOURCE;
    assign w_pc4 = bus.iPREVIOUS_EX_BRANCH_PC + ADDR_W'(4);

    // Jump class only redirects on a wrong direction or a wrong taken target.
    always_comb begin
        w_redirect = 1'b0;
        w_kind     = KIND_JUMP;
        w_addr     = '0;
        case (bus.iPREVIOUS_EX_BRANCH_CMD)
            EXE_BRANCH_SWI: begin
                w_redirect = 1'b1;
                w_kind     = KIND_SWI;
            end
            EXE_BRANCH_INTB: begin
                w_redirect = 1'b1;
                w_kind     = KIND_INTB;
                w_addr     = w_target;
            end
            EXE_BRANCH_IDTS: begin
                w_redirect = 1'b1;
                w_kind     = KIND_IDTS;
            end
            default: begin
                w_redirect = (w_taken != bus.iPREVIOUS_EX_BRANCH_PRED_TAKEN) ||
                             (w_taken && (w_target != bus.iPREVIOUS_EX_BRANCH_PRED_ADDR));
                w_kind     = KIND_JUMP;
                w_addr     = w_taken ? w_target : w_pc4;
            end
        endcase
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_lock           = 1'b0;
        w_redirect_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_redirect) begin
                    w_state_next = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                w_lock           = 1'b1;
                w_redirect_valid = 1'b1;
                if (bus.iREDIRECT_ACK) begin
                    w_state_next = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                w_lock = 1'b1;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        if (w_restart) begin
            w_state_next = ST_IDLE;
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_sche_valid <= 1'b0;
            r_sche_tag   <= '0;
            r_kind       <= '0;
            r_addr       <= '0;
            r_rtag       <= '0;
            r_swi        <= '0;
            r_idts       <= '0;
        end else if (w_restart) begin
            r_sche_valid <= 1'b0;
            r_kind       <= '0;
            r_addr       <= '0;
            r_rtag       <= '0;
        end else begin
            r_sche_valid <= w_accept;
            if (w_accept) begin
                r_sche_tag <= bus.iPREVIOUS_EX_BRANCH_COMMIT_TAG;
            end
            if (w_accept && w_redirect) begin
                r_kind <= w_kind;
                r_addr <= w_addr;
                r_rtag <= bus.iPREVIOUS_EX_BRANCH_COMMIT_TAG;
                if (w_kind == KIND_SWI) begin
                    r_swi <= bus.iPREVIOUS_EX_BRANCH_SOURCE[10:0];
                end
                if (w_kind == KIND_IDTS) begin
                    r_idts <= w_pc4;
                end
            end
        end
    end

    // Statistics survive pipeline flushes; only the hard reset clears them.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_bcnt <= '0;
            r_mcnt <= '0;
        end else begin
            if (w_accept && (r_bcnt != '1)) begin
                r_bcnt <= r_bcnt + CNT_W'(1);
            end
            if (w_accept && w_redirect && (w_kind == KIND_JUMP) && (r_mcnt != '1)) begin
                r_mcnt <= r_mcnt + CNT_W'(1);
            end
        end
    end

    assign bus.oPREVIOUS_EX_BRANCH_LOCK   = w_lock;
    assign bus.oREDIRECT_VALID            = w_redirect_valid;
    assign bus.oREDIRECT_KIND             = r_kind;
    assign bus.oREDIRECT_ADDR             = r_addr;
    assign bus.oREDIRECT_COMMIT_TAG       = r_rtag;
    assign bus.oSWI_NUMBER                = r_swi;
    assign bus.oIDTS_R_ADDR               = r_idts;
    assign bus.oSCHE_EX_BRANCH_VALID      = {NUM_SCHE{r_sche_valid}};
    assign bus.oSCHE_EX_BRANCH_COMMIT_TAG = r_sche_tag;
    assign bus.oSTAT_BRANCH_CNT           = r_bcnt;
    assign bus.oSTAT_MISPRED_CNT          = r_mcnt;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: table vectors, directed races and a random
// run, all compared against a behavioural model of the stage.
module tb_branch_resolve_unit;
    import branch_resolve_unit_pkg::*;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned TAG_W    = 6;
    localparam int unsigned NUM_SCHE = 2;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned CMAX     = (1 << CNT_W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_resolve_unit_if #(.ADDR_W(ADDR_W), .TAG_W(TAG_W), .NUM_SCHE(NUM_SCHE), .CNT_W(CNT_W)) bus ();

    branch_resolve_unit #(.ADDR_W(ADDR_W), .TAG_W(TAG_W), .NUM_SCHE(NUM_SCHE), .CNT_W(CNT_W)) dut (
        .iCLOCK (clk),
        .inRESET(rst_n),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: "asking" = redirect outstanding, "holding" = acknowledged, waiting for flush.
    bit                 m_asking, m_holding;
    bit                 m_sche_v;
    logic [TAG_W-1:0]   m_sche_tag;
    logic [1:0]         m_kind;
    logic [ADDR_W-1:0]  m_addr;
    logic [TAG_W-1:0]   m_rtag;
    logic [10:0]        m_swi;
    logic [ADDR_W-1:0]  m_idts;
    int unsigned        m_bcnt, m_mcnt;

    typedef struct {
        logic [4:0]        cmd;
        logic [3:0]        cc;
        logic [4:0]        flags;
        logic [ADDR_W-1:0] src;
        logic [ADDR_W-1:0] pc;
        logic              pt;
        logic [ADDR_W-1:0] pa;
        logic [TAG_W-1:0]  tag;
        logic              e_redir;
        logic [1:0]        e_kind;
        logic [ADDR_W-1:0] e_addr;
        logic [10:0]       e_swi;
        logic [ADDR_W-1:0] e_idts;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit ref_taken(input logic [3:0] cc, input logic [4:0] f);
        bit cf, of, sf, pf, zf;
        cf = f[FLAGS_CF]; of = f[FLAGS_OF]; sf = f[FLAGS_SF]; pf = f[FLAGS_PF]; zf = f[FLAGS_ZF];
        case (cc)
            CC_EQ:  return zf;
            CC_NEQ: return !zf;
            CC_MI:  return sf;
            CC_PL:  return !sf;
            CC_EN:  return !pf;
            CC_ON:  return pf;
            CC_OVF: return of;
            CC_UEO: return cf;
            CC_UU:  return !cf;
            CC_UO:  return cf && !zf;
            CC_UEU: return !cf || zf;
            CC_SEO: return sf == of;
            CC_SU:  return sf != of;
            CC_SO:  return !((sf != of) || zf);
            CC_SEU: return (sf != of) || zf;
            default: return 1'b1;
        endcase
    endfunction

    task automatic model_reset();
        m_asking = 0; m_holding = 0; m_sche_v = 0; m_sche_tag = '0;
        m_kind = '0; m_addr = '0; m_rtag = '0; m_swi = '0; m_idts = '0;
        m_bcnt = 0; m_mcnt = 0;
    endtask

    task automatic model_edge();
        bit accept, taken, redir;
        logic [ADDR_W-1:0] tgt, pc, src;
        logic [4:0] cmd;
        if (bus.iFREE_RESTART) begin
            m_asking = 0; m_holding = 0; m_sche_v = 0;
            m_kind = '0; m_addr = '0; m_rtag = '0;
            return;
        end
        accept = bus.iPREVIOUS_EX_BRANCH_VALID && !m_asking && !m_holding;
        m_sche_v = accept;
        if (m_asking && bus.iREDIRECT_ACK) begin
            m_asking = 0; m_holding = 1;
        end
        if (!accept) return;
        m_sche_tag = bus.iPREVIOUS_EX_BRANCH_COMMIT_TAG;
        if (m_bcnt < CMAX) m_bcnt++;
        cmd = bus.iPREVIOUS_EX_BRANCH_CMD;
        pc  = bus.iPREVIOUS_EX_BRANCH_PC;
        src = bus.iPREVIOUS_EX_BRANCH_SOURCE;
        tgt = (cmd == EXE_BRANCH_BR || cmd == EXE_BRANCH_BUR) ? pc + src : src;
        taken = ref_taken(bus.iPREVIOUS_EX_BRANCH_CC, bus.iPREVIOUS_EX_BRANCH_FLAG);
        if (cmd == EXE_BRANCH_SWI) begin
            m_kind = KIND_SWI; m_addr = '0; m_swi = src[10:0]; redir = 1;
        end else if (cmd == EXE_BRANCH_INTB) begin
            m_kind = KIND_INTB; m_addr = src; redir = 1;
        end else if (cmd == EXE_BRANCH_IDTS) begin
            m_kind = KIND_IDTS; m_addr = '0; m_idts = pc + 32'd4; redir = 1;
        end else begin
            redir = (taken != bus.iPREVIOUS_EX_BRANCH_PRED_TAKEN) ||
                    (taken && tgt != bus.iPREVIOUS_EX_BRANCH_PRED_ADDR);
            if (redir) begin
                m_kind = KIND_JUMP;
                m_addr = taken ? tgt : pc + 32'd4;
                if (m_mcnt < CMAX) m_mcnt++;
            end
        end
        if (redir) begin
            m_rtag = bus.iPREVIOUS_EX_BRANCH_COMMIT_TAG;
            m_asking = 1;
        end
    endtask

    task automatic compare_all();
        chk("lock", bus.oPREVIOUS_EX_BRANCH_LOCK, m_asking || m_holding);
        chk("redirect_valid", bus.oREDIRECT_VALID, m_asking);
        chk("redirect_kind", bus.oREDIRECT_KIND, m_kind);
        chk("redirect_addr", bus.oREDIRECT_ADDR, m_addr);
        chk("redirect_tag", bus.oREDIRECT_COMMIT_TAG, m_rtag);
        chk("swi_number", bus.oSWI_NUMBER, m_swi);
        chk("idts_r_addr", bus.oIDTS_R_ADDR, m_idts);
        chk("sche_valid", bus.oSCHE_EX_BRANCH_VALID, {NUM_SCHE{m_sche_v}});
        if (m_sche_v) chk("sche_tag", bus.oSCHE_EX_BRANCH_COMMIT_TAG, m_sche_tag);
        chk("branch_cnt", bus.oSTAT_BRANCH_CNT, m_bcnt);
        chk("mispred_cnt", bus.oSTAT_MISPRED_CNT, m_mcnt);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic set_in(input logic [4:0] cmd, input logic [3:0] cc, input logic [4:0] fl,
                          input logic [ADDR_W-1:0] src, input logic [ADDR_W-1:0] pc,
                          input logic pt, input logic [ADDR_W-1:0] pa, input logic [TAG_W-1:0] tag);
        bus.iPREVIOUS_EX_BRANCH_CMD        = cmd;
        bus.iPREVIOUS_EX_BRANCH_CC         = cc;
        bus.iPREVIOUS_EX_BRANCH_FLAG       = fl;
        bus.iPREVIOUS_EX_BRANCH_SOURCE     = src;
        bus.iPREVIOUS_EX_BRANCH_PC         = pc;
        bus.iPREVIOUS_EX_BRANCH_PRED_TAKEN = pt;
        bus.iPREVIOUS_EX_BRANCH_PRED_ADDR  = pa;
        bus.iPREVIOUS_EX_BRANCH_COMMIT_TAG = tag;
    endtask

    task automatic flush();
        bus.iPREVIOUS_EX_BRANCH_VALID = 0;
        bus.iREDIRECT_ACK = 0;
        bus.iFREE_RESTART = 1;
        tick();
        bus.iFREE_RESTART = 0;
    endtask

    task automatic mispredict(input logic [TAG_W-1:0] tag);
        set_in(EXE_BRANCH_BR, CC_AL, 5'h0, 32'h40, 32'h1000, 1'b0, 32'h0, tag);
        bus.iPREVIOUS_EX_BRANCH_VALID = 1;
        tick();
        bus.iPREVIOUS_EX_BRANCH_VALID = 0;
    endtask

    initial begin
        int unsigned saved;
        logic [ADDR_W-1:0] pc, src;
        bus.iFREE_RESTART = 0;
        bus.iPREVIOUS_EX_BRANCH_VALID = 0;
        bus.iREDIRECT_ACK = 0;
        set_in(5'h0, 4'h0, 5'h0, '0, '0, 1'b0, '0, '0);
        model_reset();

        tbl.push_back('{EXE_BRANCH_BR,  CC_NEQ, 5'b10000, 32'h80, 32'h2000, 1, 32'h2080, 6'h11, 1, KIND_JUMP, 32'h2004, 11'h0, 32'h0});
        tbl.push_back('{EXE_BRANCH_B,   CC_AL,  5'b00000, 32'h3000, 32'h50, 1, 32'h3008, 6'h12, 1, KIND_JUMP, 32'h3000, 11'h0, 32'h0});
        tbl.push_back('{EXE_BRANCH_SWI, CC_AL,  5'b00000, 32'h7FF, 32'h60, 0, 32'h0, 6'h13, 1, KIND_SWI, 32'h0, 11'h7FF, 32'h0});
        tbl.push_back('{EXE_BRANCH_IDTS, CC_AL, 5'b00000, 32'h0, 32'hFFFFFFFC, 0, 32'h0, 6'h14, 1, KIND_IDTS, 32'h0, 11'h0, 32'h0});
        tbl.push_back('{EXE_BRANCH_INTB, CC_EQ, 5'b00000, 32'h80000100, 32'h70, 0, 32'h0, 6'h15, 1, KIND_INTB, 32'h80000100, 11'h0, 32'h0});
        tbl.push_back('{EXE_BRANCH_BR,  CC_EQ,  5'b10000, 32'h20, 32'h100, 1, 32'h120, 6'h16, 0, KIND_JUMP, 32'h0, 11'h0, 32'h0});
        tbl.push_back('{EXE_BRANCH_BUR, CC_SU,  5'b00100, 32'hFFFFFFF0, 32'h20, 0, 32'h0, 6'h17, 1, KIND_JUMP, 32'h10, 11'h0, 32'h0});
        tbl.push_back('{EXE_BRANCH_B,   CC_SO,  5'b00110, 32'h400, 32'h90, 1, 32'h400, 6'h18, 0, KIND_JUMP, 32'h0, 11'h0, 32'h0});
        tbl.push_back('{EXE_BRANCH_B,   CC_UO,  5'b10001, 32'h440, 32'h94, 0, 32'h0, 6'h19, 0, KIND_JUMP, 32'h0, 11'h0, 32'h0});
        tbl.push_back('{EXE_BRANCH_BU,  CC_UEU, 5'b00000, 32'h500, 32'h98, 0, 32'h0, 6'h1A, 1, KIND_JUMP, 32'h500, 11'h0, 32'h0});
        tbl.push_back('{EXE_BRANCH_B,   CC_EN,  5'b01000, 32'h700, 32'h600, 1, 32'h700, 6'h1B, 1, KIND_JUMP, 32'h604, 11'h0, 32'h0});

        // Reset state
        #2;
        compare_all();
        chk("reset_lock", bus.oPREVIOUS_EX_BRANCH_LOCK, 1'b0);
        #10 rst_n = 1;

        // Correct not-taken: completion only, for exactly one cycle
        set_in(EXE_BRANCH_B, CC_EQ, 5'b00000, 32'h800, 32'h10, 1'b0, 32'h0, 6'h05);
        bus.iPREVIOUS_EX_BRANCH_VALID = 1;
        tick();
        bus.iPREVIOUS_EX_BRANCH_VALID = 0;
        chk("nt_sche_valid", bus.oSCHE_EX_BRANCH_VALID, 2'b11);
        chk("nt_sche_tag", bus.oSCHE_EX_BRANCH_COMMIT_TAG, 6'h05);
        chk("nt_no_redirect", bus.oREDIRECT_VALID, 1'b0);
        chk("nt_branch_cnt", bus.oSTAT_BRANCH_CNT, 4'd1);
        chk("nt_mispred_cnt", bus.oSTAT_MISPRED_CNT, 4'd0);
        tick();
        chk("nt_strobe_drop", bus.oSCHE_EX_BRANCH_VALID, 2'b00);

        // Taken mispredict, held request, ack, locked, release
        mispredict(6'h21);
        chk("mp_valid", bus.oREDIRECT_VALID, 1'b1);
        chk("mp_lock", bus.oPREVIOUS_EX_BRANCH_LOCK, 1'b1);
        chk("mp_addr", bus.oREDIRECT_ADDR, 32'h1040);
        chk("mp_kind", bus.oREDIRECT_KIND, KIND_JUMP);
        chk("mp_sche", bus.oSCHE_EX_BRANCH_VALID, 2'b11);
        chk("mp_cnt", bus.oSTAT_MISPRED_CNT, 4'd1);
        set_in(EXE_BRANCH_SWI, CC_AL, 5'h0, 32'h123, 32'h0, 1'b0, 32'h0, 6'h22);
        bus.iPREVIOUS_EX_BRANCH_VALID = 1;
        for (int i = 0; i < 3; i++) tick();
        bus.iPREVIOUS_EX_BRANCH_VALID = 0;
        chk("hold_valid", bus.oREDIRECT_VALID, 1'b1);
        chk("hold_addr", bus.oREDIRECT_ADDR, 32'h1040);
        chk("hold_tag", bus.oREDIRECT_COMMIT_TAG, 6'h21);
        chk("hold_bcnt", bus.oSTAT_BRANCH_CNT, 4'd2);
        bus.iREDIRECT_ACK = 1;
        tick();
        bus.iREDIRECT_ACK = 0;
        chk("ack_valid", bus.oREDIRECT_VALID, 1'b0);
        chk("ack_lock", bus.oPREVIOUS_EX_BRANCH_LOCK, 1'b1);
        tick();
        chk("locked_stays", bus.oPREVIOUS_EX_BRANCH_LOCK, 1'b1);
        flush();
        chk("release_lock", bus.oPREVIOUS_EX_BRANCH_LOCK, 1'b0);
        chk("release_addr", bus.oREDIRECT_ADDR, 32'h0);

        // Table vectors
        foreach (tbl[i]) begin
            set_in(tbl[i].cmd, tbl[i].cc, tbl[i].flags, tbl[i].src, tbl[i].pc, tbl[i].pt, tbl[i].pa, tbl[i].tag);
            bus.iPREVIOUS_EX_BRANCH_VALID = 1;
            tick();
            bus.iPREVIOUS_EX_BRANCH_VALID = 0;
            chk("tbl_redirect", bus.oREDIRECT_VALID, tbl[i].e_redir);
            chk("tbl_sche_tag", bus.oSCHE_EX_BRANCH_COMMIT_TAG, tbl[i].tag);
            if (tbl[i].e_redir) begin
                chk("tbl_kind", bus.oREDIRECT_KIND, tbl[i].e_kind);
                chk("tbl_addr", bus.oREDIRECT_ADDR, tbl[i].e_addr);
                chk("tbl_rtag", bus.oREDIRECT_COMMIT_TAG, tbl[i].tag);
            end
            if (tbl[i].cmd == EXE_BRANCH_SWI) chk("tbl_swi", bus.oSWI_NUMBER, tbl[i].e_swi);
            if (tbl[i].cmd == EXE_BRANCH_IDTS) chk("tbl_idts", bus.oIDTS_R_ADDR, tbl[i].e_idts);
            flush();
        end

        // Restart coincident with a valid input drops it
        saved = bus.oSTAT_BRANCH_CNT;
        set_in(EXE_BRANCH_BR, CC_AL, 5'h0, 32'h8, 32'h0, 1'b0, 32'h0, 6'h30);
        bus.iPREVIOUS_EX_BRANCH_VALID = 1;
        bus.iFREE_RESTART = 1;
        tick();
        bus.iPREVIOUS_EX_BRANCH_VALID = 0;
        bus.iFREE_RESTART = 0;
        chk("race_valid_sche", bus.oSCHE_EX_BRANCH_VALID, 2'b00);
        chk("race_valid_redir", bus.oREDIRECT_VALID, 1'b0);
        chk("race_valid_bcnt", bus.oSTAT_BRANCH_CNT, saved);

        // Restart coincident with ack returns to idle
        mispredict(6'h31);
        bus.iREDIRECT_ACK = 1;
        bus.iFREE_RESTART = 1;
        tick();
        bus.iREDIRECT_ACK = 0;
        bus.iFREE_RESTART = 0;
        chk("race_ack_lock", bus.oPREVIOUS_EX_BRANCH_LOCK, 1'b0);

        // Asynchronous reset in the middle of a redirect
        mispredict(6'h32);
        #1 rst_n = 0;
        #1;
        model_reset();
        compare_all();
        chk("areset_valid", bus.oREDIRECT_VALID, 1'b0);
        chk("areset_cnt", bus.oSTAT_MISPRED_CNT, 4'd0);
        #2 rst_n = 1;

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            pc  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            src = $urandom;
            bus.iPREVIOUS_EX_BRANCH_VALID = ($urandom_range(0, 9) < 7);
            bus.iREDIRECT_ACK             = $urandom_range(0, 1);
            bus.iFREE_RESTART             = ($urandom_range(0, 14) == 0);
            bus.iPREVIOUS_EX_BRANCH_CMD   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 6));
            bus.iPREVIOUS_EX_BRANCH_CC    = 4'($urandom);
            bus.iPREVIOUS_EX_BRANCH_FLAG  = 5'($urandom);
            bus.iPREVIOUS_EX_BRANCH_SOURCE = src;
            bus.iPREVIOUS_EX_BRANCH_PC    = pc;
            bus.iPREVIOUS_EX_BRANCH_PRED_TAKEN = $urandom_range(0, 1);
            case ($urandom_range(0, 2))
                0:       bus.iPREVIOUS_EX_BRANCH_PRED_ADDR = $urandom;
                1:       bus.iPREVIOUS_EX_BRANCH_PRED_ADDR = pc + src;
                default: bus.iPREVIOUS_EX_BRANCH_PRED_ADDR = src;
            endcase
            bus.iPREVIOUS_EX_BRANCH_COMMIT_TAG = 6'($urandom);
            tick();
        end
        flush();

        // Counter saturation from a cleared start
        @(negedge clk) rst_n = 0;
        model_reset();
        #1 rst_n = 1;
        for (int i = 0; i < 20; i++) begin
            mispredict(6'($urandom));
            flush();
        end
        chk("sat_branch_cnt", bus.oSTAT_BRANCH_CNT, 4'hF);
        chk("sat_mispred_cnt", bus.oSTAT_MISPRED_CNT, 4'hF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
